// File: rtl/lock_pkg.sv
// Shared types and constants for the serial lock code checker.
package lock_pkg;

   typedef enum logic [1:0] {
      ENTRY    = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2
   } lock_state_t;

   localparam logic [7:0]  RELOCK_KEY = 8'h23;
   localparam int unsigned FAIL_W     = 3;
   localparam int unsigned ENTRY_W    = 4;

   // Code bytes are packed with the first expected byte in the most significant occupied byte.
   function automatic logic [7:0] code_byte(input logic [63:0] code,
                                            input int unsigned len,
                                            input int unsigned idx);
      return 8'(code >> (8 * (len - 1 - idx)));
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock-hold and lockout phases; stops at zero.
module lock_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic [WIDTH-1:0] o_value,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_value;
      else if (r_count != '0)
         r_count <= r_count - WIDTH'(1);
   end

   assign o_value   = r_count;
   assign o_expired = (r_count == WIDTH'(1)) && !i_load;

endmodule

// File: rtl/lock_code_checker.sv
// Serial code lock: checks a fixed byte sequence, holds open, locks out after repeated failures.
// Optional '#' relock/clear key enabled by defining LOCK_RELOCK_KEY_EN.
module lock_code_checker
   import lock_pkg::*;
#(
   parameter int unsigned CLK_FREQ       = 100_000_000,
   parameter int unsigned CODE_LEN       = 4,
   parameter logic [63:0] CODE           = 64'h31_32_33_34,
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned UNLOCK_CYCLES  = CLK_FREQ * 5,
   parameter int unsigned LOCKOUT_CYCLES = CLK_FREQ * 30,
   parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ * 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               unlocked,
   output logic               alarm,
   output logic [FAIL_W-1:0]  fail_count,
   output logic [ENTRY_W-1:0] entry_count
);

   localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);
   localparam int unsigned GW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ENTRY_W-1:0] LAST_IDX = ENTRY_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0]  MAX_FAIL = FAIL_W'(MAX_ATTEMPTS);
   localparam logic [GW-1:0]      GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

   lock_state_t        r_state, w_state_nx;
   logic [ENTRY_W-1:0] r_entry, w_entry_nx;
   logic [FAIL_W-1:0]  r_fail, w_fail_nx, w_fail_inc;
   logic [GW-1:0]      r_gap, w_gap_nx;
   logic               r_mismatch, w_mismatch_nx;
   logic               w_byte_mis, w_relock;
   logic               w_tmr_load, w_tmr_expired;
   logic [TW-1:0]      w_tmr_load_val, w_tmr_value;

`ifdef LOCK_RELOCK_KEY_EN
   assign w_relock = (rx_data == RELOCK_KEY);
`else
   assign w_relock = 1'b0;
`endif

   assign w_byte_mis = (rx_data != code_byte(CODE, CODE_LEN, 32'(r_entry)));
   assign w_fail_inc = (r_fail >= MAX_FAIL) ? r_fail : r_fail + FAIL_W'(1);

   lock_timer #(.WIDTH(TW)) u_timer (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_load       (w_tmr_load),
      .i_load_value (w_tmr_load_val),
      .o_value      (w_tmr_value),
      .o_expired    (w_tmr_expired)
   );

   always_comb begin
      w_state_nx     = r_state;
      w_entry_nx     = r_entry;
      w_mismatch_nx  = r_mismatch;
      w_fail_nx      = r_fail;
      w_gap_nx       = r_gap;
      w_tmr_load     = 1'b0;
      w_tmr_load_val = '0;
      case (r_state)
         ENTRY: begin
            // A relock leaves the timer mid-count; park it at zero while idle.
            if (w_tmr_value != '0)
               w_tmr_load = 1'b1;
            if (rx_valid && w_relock) begin
               w_entry_nx    = '0;
               w_mismatch_nx = 1'b0;
               w_gap_nx      = '0;
            end else if (rx_valid) begin
               w_gap_nx = '0;
               if (r_entry == LAST_IDX) begin
                  w_entry_nx    = '0;
                  w_mismatch_nx = 1'b0;
                  if (!(r_mismatch || w_byte_mis)) begin
                     w_state_nx     = UNLOCKED;
                     w_tmr_load     = 1'b1;
                     w_tmr_load_val = TW'(UNLOCK_CYCLES);
                     w_fail_nx      = '0;
                  end else begin
                     w_fail_nx = w_fail_inc;
                     if (w_fail_inc == MAX_FAIL) begin
                        w_state_nx     = LOCKOUT;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = TW'(LOCKOUT_CYCLES);
                     end
                  end
               end else begin
                  w_entry_nx    = r_entry + ENTRY_W'(1);
                  w_mismatch_nx = r_mismatch || w_byte_mis;
               end
            end else if (r_entry != '0) begin
               if (r_gap == GAP_LAST) begin
                  w_entry_nx    = '0;
                  w_mismatch_nx = 1'b0;
                  w_gap_nx      = '0;
               end else begin
                  w_gap_nx = r_gap + GW'(1);
               end
            end
         end
         UNLOCKED: begin
            if (w_tmr_expired || (rx_valid && w_relock))
               w_state_nx = ENTRY;
         end
         LOCKOUT: begin
            if (w_tmr_expired) begin
               w_state_nx = ENTRY;
               w_fail_nx  = '0;
            end
         end
         default: w_state_nx = ENTRY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ENTRY;
         r_entry    <= '0;
         r_mismatch <= 1'b0;
         r_fail     <= '0;
         r_gap      <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_entry    <= w_entry_nx;
         r_mismatch <= w_mismatch_nx;
         r_fail     <= w_fail_nx;
         r_gap      <= w_gap_nx;
      end
   end

   assign unlocked    = (r_state == UNLOCKED);
   assign alarm       = (r_state == LOCKOUT);
   assign fail_count  = r_fail;
   assign entry_count = r_entry;

endmodule

// File: doc/lock_code_checker.md
LOCK_CODE_CHECKER -- requirements
Module: lock_code_checker

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, the system clock frequency in Hz.
REQ-002 SHALL have parameter CODE_LEN, default 4, the number of code bytes (legal range 1..8).
REQ-003 SHALL have parameter CODE, default 32'h31_32_33_34 ("1234"), holding the code bytes; the first expected byte is in the most significant occupied byte.
REQ-004 SHALL have parameter MAX_ATTEMPTS, default 3, the number of failed entries before lockout (legal range 1..7).
REQ-005 SHALL have parameter UNLOCK_CYCLES, default CLK_FREQ*5, the unlocked hold time in clock cycles.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default CLK_FREQ*30, the lockout duration in clock cycles.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default CLK_FREQ*3, the maximum gap between bytes within one entry.
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-010 SHALL have port rx_data, input, 8 bits, the byte from the UART receiver.
REQ-011 SHALL have port rx_valid, input, 1 bit, a one-cycle strobe marking rx_data as a new byte.
REQ-012 SHALL have port unlocked, output, 1 bit, high while the lock is open.
REQ-013 SHALL have port alarm, output, 1 bit, high during lockout.
REQ-014 SHALL have port fail_count, output, 3 bits, the number of consecutive failed entries.
REQ-015 SHALL have port entry_count, output, 4 bits, the number of bytes accepted in the current entry.

Function
REQ-016 SHALL implement an FSM with states ENTRY, UNLOCKED and LOCKOUT; the state after reset is ENTRY.
REQ-017 In ENTRY, each rx_valid SHALL, on the next edge:
- compare rx_data against code byte number entry_count;
- OR any mismatch into a sticky mismatch flag;
- increment entry_count.
REQ-018 SHALL never abort an entry early on a mismatch; exactly CODE_LEN bytes are always consumed.
REQ-019 On the byte that makes entry_count reach CODE_LEN, the checker SHALL clear entry_count and mismatch on the next edge and decide in that same cycle:
- clean match: go to UNLOCKED, load the timer with UNLOCK_CYCLES, clear fail_count;
- mismatch: increment fail_count.
REQ-020 If a failed entry makes fail_count equal MAX_ATTEMPTS, the checker SHALL go to LOCKOUT and load the timer with LOCKOUT_CYCLES.
REQ-021 unlocked SHALL be high exactly in UNLOCKED, rising one cycle after the final byte's strobe.
REQ-022 alarm SHALL be high exactly in LOCKOUT.
REQ-023 UNLOCKED SHALL last exactly UNLOCK_CYCLES cycles, then return to ENTRY.
REQ-024 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then return to ENTRY with fail_count cleared.
REQ-025 rx_valid in UNLOCKED or LOCKOUT SHALL be ignored, except as stated in REQ-032; this includes a strobe in the cycle the timer expires.
REQ-026 In ENTRY with entry_count > 0, a gap of TIMEOUT_CYCLES cycles with no rx_valid SHALL discard the partial entry: entry_count and mismatch clear, fail_count is unchanged.
REQ-027 If rx_valid coincides with timeout expiry, the byte SHALL win: it is accepted and the gap counter restarts.
REQ-028 The timer SHALL be a down-counter sized by $clog2 of the largest cycle parameter; wrap-around is prohibited.
REQ-029 fail_count SHALL saturate at MAX_ATTEMPTS.

Reset
REQ-030 reset SHALL force ENTRY; unlocked, alarm, fail_count, entry_count, the mismatch flag, the timer and the gap counter all go to 0 on the same edge.
REQ-031 reset SHALL take priority over rx_valid and over timer expiry, including mid-entry, mid-unlock and mid-lockout.

Configuration
REQ-032 With LOCK_RELOCK_KEY_EN defined:
- rx_data 8'h23 ('#') with rx_valid in UNLOCKED returns to ENTRY on the next edge;
- 8'h23 in ENTRY discards the partial entry without counting a failure.
Without the macro, 8'h23 is an ordinary code byte.

Structure
REQ-033 Package lock_pkg SHALL hold the state enum (ENTRY/UNLOCKED/LOCKOUT), the RELOCK_KEY constant 8'h23, and the width constants for fail_count and entry_count.
REQ-034 Sub-module lock_timer SHALL provide a loadable down-counter with load, value and a one-cycle expired output, shared between the unlock and lockout phases.

Verification
REQ-035 The bench SHALL cover these scenarios, with UNLOCK_CYCLES=20, LOCKOUT_CYCLES=40, TIMEOUT_CYCLES=10:
- bytes "1234" -> unlocked rises 1 cycle after the 4th strobe, stays high 20 cycles, fail_count=0;
- "1235" three times -> fail_count goes 1, 2, 3; alarm high for 40 cycles; then fail_count=0; "1234" sent during lockout is ignored;
- "12", 10-cycle gap, "1234" -> unlocks; fail_count=0;
- "12", gap of 9 cycles, then byte on cycle 10 -> accepted; entry_count=3;
- reset asserted mid-unlock and after 2 failures -> all outputs 0 next edge;
- with LOCK_RELOCK_KEY_EN: "1234" then "#" -> unlocked falls next edge.
